// File: rtl/jtframe_dcrm_pkg.sv
// Shared definitions for the time-multiplexed DC-removal engine.
//   DW        : fractional bits of each channel integrator
//   dcrm_state_e : scheduler states (IDLE, RUN, DONE)
//   state_w() : width of the per-channel integrator/error state for a
//               given sample width (SW + DW + 1, signed)
package jtframe_dcrm_pkg;

    localparam int DW = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dcrm_state_e;

    function automatic int state_w(input int sw);
        return sw + DW + 1;
    endfunction

endpackage

// File: rtl/jtframe_dcrm_step.sv
// Single-channel DC-removal step, purely combinational.
//   din        : channel sample (unsigned or two's complement per SIGNED_INPUT)
//   integ      : current integrator state (signed, SW+DW+1 bits)
//   error      : current quantisation error state (SW+DW+1 bits)
//   en         : 1 = filter, 0 = bypass (output = din, state forced to 0)
//   dout       : filtered sample (signed, SW bits)
//   integ_next : updated integrator state
//   error_next : updated error state
// All arithmetic wraps modulo 2^(SW+DW+1); there is no saturation.
module jtframe_dcrm_step
    import jtframe_dcrm_pkg::*;
#(
    parameter int SW           = 8,
    parameter int SIGNED_INPUT = 0
) (
    input  logic [SW-1:0]  din,
    input  logic [SW+DW:0] integ,
    input  logic [SW+DW:0] error,
    input  logic           en,
    output logic [SW-1:0]  dout,
    output logic [SW+DW:0] integ_next,
    output logic [SW+DW:0] error_next
);

    logic [SW+DW:0] exact;
    logic [SW:0]    q;
    logic [SW:0]    pre;
    logic           ext;

    always_comb begin
        exact = integ + error;
        // Integer part of the integrator is the current DC estimate.
        q     = exact[SW+DW:DW];
        ext   = (SIGNED_INPUT != 0) ? din[SW-1] : 1'b0;
        pre   = {ext, din} - q;
        if (en) begin
            dout       = pre[SW-1:0];
            integ_next = integ + {{DW{pre[SW]}}, pre};
            // Keep the fractional residue so truncation error is fed back.
            error_next = exact - {q, {DW{1'b0}}};
        end else begin
            dout       = din;
            integ_next = '0;
            error_next = '0;
        end
    end

endmodule

// File: rtl/jtframe_dcrm_mux.sv
// Time-multiplexed DC-removal engine for CH channels sharing one step unit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sample      : one-cycle strobe; latches din/en and starts a pass
//   din         : packed channel inputs, channel k at [k*SW +: SW]
//   en          : per-channel enable, 0 = bypass
//   clr         : synchronous clear of channel state and ovf, aborts a pass
//   dout        : packed filtered outputs, all updated together
//   dout_valid  : one-cycle pulse when dout has been refreshed
//   busy        : a pass is in progress (RUN)
//   ovf         : sticky, set when sample arrives outside IDLE
// Handshake: sample is accepted only in IDLE; a pass started at cycle t
// runs channels over t+1..t+CH and pulses dout_valid at t+CH+1.
module jtframe_dcrm_mux
    import jtframe_dcrm_pkg::*;
#(
    parameter int CH           = 4,
    parameter int SW           = 8,
    parameter int SIGNED_INPUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic [CH*SW-1:0] din,
    input  logic [CH-1:0]    en,
    input  logic             clr,
    output logic [CH*SW-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             ovf
);

    localparam int W  = state_w(SW);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(CH - 1);

    dcrm_state_e      state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [CH*SW-1:0] inbuf_q, inbuf_d;
    logic [CH-1:0]    enbuf_q, enbuf_d;
    logic [W-1:0]     integ_q [CH];
    logic [W-1:0]     integ_d [CH];
    logic [W-1:0]     error_q [CH];
    logic [W-1:0]     error_d [CH];
    // Results collect here during RUN so dout changes all at once.
    logic [CH*SW-1:0] stage_q, stage_d;
    logic [CH*SW-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [SW-1:0]    step_din;
    logic [SW-1:0]    step_dout;
    logic [W-1:0]     step_integ_next;
    logic [W-1:0]     step_error_next;

    assign step_din = inbuf_q[int'(ch_q)*SW +: SW];

    jtframe_dcrm_step #(
        .SW           (SW),
        .SIGNED_INPUT (SIGNED_INPUT)
    ) u_step (
        .din        (step_din),
        .integ      (integ_q[ch_q]),
        .error      (error_q[ch_q]),
        .en         (enbuf_q[ch_q]),
        .dout       (step_dout),
        .integ_next (step_integ_next),
        .error_next (step_error_next)
    );

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        inbuf_d      = inbuf_q;
        enbuf_d      = enbuf_q;
        integ_d      = integ_q;
        error_d      = error_q;
        stage_d      = stage_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;
        ovf_d        = ovf_q;

        case (state_q)
            IDLE: begin
                if (sample) begin
                    inbuf_d = din;
                    enbuf_d = en;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                integ_d[ch_q]                  = step_integ_next;
                error_d[ch_q]                  = step_error_next;
                stage_d[int'(ch_q)*SW +: SW]   = step_dout;
                if (ch_q == LAST) begin
                    dout_d       = stage_d;
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = DONE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (sample && (state_q != IDLE)) begin
            ovf_d = 1'b1;
        end

        // clr wins over everything: abort, drop any sample, keep dout.
        if (clr) begin
            for (int k = 0; k < CH; k++) begin
                integ_d[k] = '0;
                error_d[k] = '0;
            end
            state_d      = IDLE;
            ch_d         = '0;
            inbuf_d      = inbuf_q;
            enbuf_d      = enbuf_q;
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
            busy_d       = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            inbuf_q      <= '0;
            enbuf_q      <= '0;
            for (int k = 0; k < CH; k++) begin
                integ_q[k] <= '0;
                error_q[k] <= '0;
            end
            stage_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            inbuf_q      <= inbuf_d;
            enbuf_q      <= enbuf_d;
            integ_q      <= integ_d;
            error_q      <= error_d;
            stage_q      <= stage_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_jtframe_dcrm_mux.sv
module tb_jtframe_dcrm_mux;

    localparam int CH = 4;
    localparam int SW = 8;
    localparam longint M = 64'd1 << 19;   // state modulus 2^(SW+10+1)

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic             sample;
    logic [CH*SW-1:0] din;
    logic [CH-1:0]    en;
    logic             clr;
    logic [CH*SW-1:0] dout_u, dout_s;
    logic             dv_u, dv_s, busy_u, busy_s, ovf_u, ovf_s;

    jtframe_dcrm_mux #(.CH(CH), .SW(SW), .SIGNED_INPUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .din(din), .en(en), .clr(clr),
        .dout(dout_u), .dout_valid(dv_u), .busy(busy_u), .ovf(ovf_u)
    );

    jtframe_dcrm_mux #(.CH(CH), .SW(SW), .SIGNED_INPUT(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .sample(sample), .din(din), .en(en), .clr(clr),
        .dout(dout_s), .dout_valid(dv_s), .busy(busy_s), .ovf(ovf_s)
    );

    // ---------------- scoreboard / model ----------------
    int tests = 0;
    int fails = 0;

    // Index 0 models the unsigned instance, index 1 the signed one.
    longint           m_integ [2][CH];
    longint           m_err   [2][CH];
    logic [CH*SW-1:0] m_dout  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < CH; k++) begin
                m_integ[s][k] = 0;
                m_err[s][k]   = 0;
            end
    endtask

    // Integrator holds the DC estimate scaled by 2^10; the output is the
    // input minus the integer part of that estimate, and the fractional
    // remainder is carried to the next sample.
    task automatic model_pass(input logic [CH*SW-1:0] d, input logic [CH-1:0] e);
        longint x, exact, q, pre, spre;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < CH; k++) begin
                x = longint'(d[k*SW +: SW]);
                if (s == 1 && x >= 128) x = x - 256;
                if (!e[k]) begin
                    m_dout[s][k*SW +: SW] = d[k*SW +: SW];
                    m_integ[s][k] = 0;
                    m_err[s][k]   = 0;
                end else begin
                    exact = (m_integ[s][k] + m_err[s][k]) % M;
                    q     = exact / 1024;
                    pre   = (((x - q) % 512) + 512) % 512;
                    m_dout[s][k*SW +: SW] = 8'(pre % 256);
                    spre  = (pre >= 256) ? pre - 512 : pre;
                    m_integ[s][k] = (((m_integ[s][k] + spre) % M) + M) % M;
                    m_err[s][k]   = exact % 1024;
                end
            end
    endtask

    // ---------------- driver ----------------
    // One full pass: sample at t, RUN over t+1..t+CH, valid at t+CH+1.
    // With ovr set, a second strobe carrying d2 is issued at t+2.
    task automatic do_pass(input logic [CH*SW-1:0] d, input logic [CH-1:0] e,
                           input bit ovr, input logic [CH*SW-1:0] d2);
        @(negedge clk);
        chk("idle_busy", busy_u, 1'b0);
        chk("idle_hold", dout_u, m_dout[0]);
        din = d; en = e; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        din = $urandom;
        en  = 4'($urandom);
        for (int i = 0; i < CH; i++) begin
            chk("run_busy_u", busy_u, 1'b1);
            chk("run_busy_s", busy_s, 1'b1);
            chk("run_nvalid", {dv_u, dv_s}, 2'b00);
            if (ovr && i == 1) begin
                sample = 1'b1;
                din    = d2;
            end
            if (ovr && i == 2) begin
                sample = 1'b0;
                chk("ovf_set", {ovf_u, ovf_s}, 2'b11);
            end
            @(negedge clk);
        end
        model_pass(d, e);
        chk("done_valid", {dv_u, dv_s}, 2'b11);
        chk("done_busy", {busy_u, busy_s}, 2'b00);
        chk("dout_u", dout_u, m_dout[0]);
        chk("dout_s", dout_s, m_dout[1]);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    // ---------------- directed sequence ----------------
    logic [CH*SW-1:0] d;
    logic [CH-1:0]    e;
    logic [7:0]       d0;

    initial begin
        rst_n = 1'b0; sample = 1'b0; clr = 1'b0; din = '0; en = '0;
        model_clear();
        m_dout[0] = '0;
        m_dout[1] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1. reset mid-pass (with ovf raised), then the first pass
        @(negedge clk);
        din = $urandom; en = 4'hF; sample = 1'b1;
        @(negedge clk); sample = 1'b0;
        @(negedge clk); sample = 1'b1;
        @(negedge clk); sample = 1'b0;
        chk("pre_rst_ovf", ovf_u, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout_u", dout_u, '0);
        chk("rst_dout_s", dout_s, '0);
        chk("rst_flags", {dv_u, busy_u, ovf_u, dv_s, busy_s, ovf_s}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        do_pass(32'h4000107F, 4'hF, 1'b0, '0);
        chk("first_dout", dout_u, 32'h4000107F);
        @(negedge clk);
        chk("valid_once", {dv_u, dv_s}, 2'b00);

        // 4. bypass on ch2, then re-enable
        for (int p = 0; p < 20; p++) begin
            d = $urandom;
            d[23:16] = 8'hA5;
            do_pass(d, 4'b1011, 1'b0, '0);
            chk("bypass_ch2", dout_u[23:16], 8'hA5);
        end
        d = $urandom;
        d[23:16] = 8'hA5;
        do_pass(d, 4'hF, 1'b0, '0);
        chk("reen_ch2", dout_u[23:16], 8'hA5);

        // 3. overrun: second strobe at t+2 must be ignored
        do_pass($urandom, 4'hF, 1'b1, $urandom);
        @(negedge clk);
        chk("ovf_sticky", {ovf_u, ovf_s}, 2'b11);
        pulse_clr();
        chk("ovf_clr", {ovf_u, ovf_s}, 2'b00);
        d = $urandom;
        do_pass(d, 4'hF, 1'b0, '0);
        chk("post_clr", dout_u, d);

        // 6. clr with sample in IDLE
        @(negedge clk);
        clr = 1'b1; sample = 1'b1; din = $urandom; en = 4'hF;
        @(negedge clk);
        clr = 1'b0; sample = 1'b0;
        model_clear();
        for (int i = 0; i < CH + 2; i++) begin
            chk("clr_smp_idle", {busy_u, dv_u, ovf_u, busy_s, dv_s, ovf_s}, 6'b0);
            chk("clr_smp_hold", dout_u, m_dout[0]);
            @(negedge clk);
        end
        // clr mid-pass aborts without a valid pulse
        din = $urandom; en = 4'hF; sample = 1'b1;
        @(negedge clk); sample = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
        for (int i = 0; i < CH + 1; i++) begin
            chk("abort_quiet", {busy_u, dv_u, busy_s, dv_s}, 4'b0);
            chk("abort_hold", dout_u, m_dout[0]);
            @(negedge clk);
        end
        d = $urandom;
        do_pass(d, 4'hF, 1'b0, '0);
        chk("abort_clean", dout_u, d);

        // 5. alternating full-scale on ch1, random elsewhere
        pulse_clr();
        for (int p = 0; p < 2000; p++) begin
            d = $urandom;
            d[15:8] = (p % 2 == 0) ? 8'h7F : 8'h80;
            e = 4'($urandom) | 4'b0010;
            do_pass(d, e, 1'b0, '0);
        end

        // 2. DC convergence on ch0
        pulse_clr();
        for (int p = 0; p < 7000; p++) begin
            d = $urandom;
            d[7:0] = 8'hC0;
            e = 4'($urandom) | 4'b0001;
            do_pass(d, e, 1'b0, '0);
        end
        d0 = dout_u[7:0];
        chk("conv_ch0", (d0 == 8'hFF || d0 == 8'h00 || d0 == 8'h01), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
